// File: rtl/hex_segment_decoder_if.sv
// Time-multiplexed 7-segment display bus: active-low segment lines and digit selects.
// The display driver is the master; the snooping decoder is the slave.
interface hex_segment_decoder_if #(
    parameter int NUM_DIGITS = 4
);
    logic [7:0]            SegIn;
    logic [NUM_DIGITS-1:0] DigitSel;

    modport master (output SegIn, output DigitSel);
    modport slave  (input  SegIn, input  DigitSel);
endinterface

// File: rtl/hex_segment_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and recovers each digit's hex value,
// committing only after a pattern has been stable for STABLE_CYCLES samples.
//
// state | meaning
// IDLE  | no digit selected (or just recovered from a multi-select)
// TRACK | one digit selected, counting identical consecutive samples
// HOLD  | current pattern committed, waiting for it to change
module hex_segment_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                      Clk,
    input  logic                      Reset,
    hex_segment_decoder_if.slave      bus,
    output logic [4*NUM_DIGITS-1:0]   Value,
    output logic [NUM_DIGITS-1:0]     DigitValid,
    output logic [NUM_DIGITS-1:0]     Blank,
    output logic [NUM_DIGITS-1:0]     Dp,
    output logic                      Update,
    output logic [IDX_W-1:0]          UpdIdx,
    output logic                      Error
);
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [7:0]              seg_q;
    logic [NUM_DIGITS-1:0]   sel_q;
    logic [4*NUM_DIGITS-1:0] value_q, value_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic                    update_q, update_d;
    logic [IDX_W-1:0]        upd_idx_q, upd_idx_d;
    logic                    error_q, error_d;

    logic                    in_found, in_multi, same;
    logic [IDX_W-1:0]        in_idx;
    logic                    code_legal, code_blank, commit;
    logic [3:0]              code_nib;

    // Returns {legal, nibble} for a 7-bit active-low g..a code.
    function automatic logic [4:0] decode7(input logic [6:0] c);
        case (c)
            7'h40: decode7 = 5'h10;
            7'h79: decode7 = 5'h11;
            7'h24: decode7 = 5'h12;
            7'h30: decode7 = 5'h13;
            7'h19: decode7 = 5'h14;
            7'h12: decode7 = 5'h15;
            7'h02: decode7 = 5'h16;
            7'h78: decode7 = 5'h17;
            7'h00: decode7 = 5'h18;
            7'h10: decode7 = 5'h19;
            7'h08: decode7 = 5'h1A;
            7'h03: decode7 = 5'h1B;
            7'h46: decode7 = 5'h1C;
            7'h21: decode7 = 5'h1D;
            7'h06: decode7 = 5'h1E;
            7'h0E: decode7 = 5'h1F;
            default: decode7 = 5'h00;
        endcase
    endfunction

    // Select class of the sample being registered this edge.
    always_comb begin
        in_found = 1'b0;
        in_multi = 1'b0;
        in_idx   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!bus.DigitSel[i]) begin
                if (in_found) in_multi = 1'b1;
                in_found = 1'b1;
                in_idx   = IDX_W'(i);
            end
        end
    end

    assign same       = (bus.SegIn == seg_q) && (bus.DigitSel == sel_q);
    assign code_legal = decode7(seg_q[6:0])[4];
    assign code_nib   = decode7(seg_q[6:0])[3:0];
    assign code_blank = (seg_q[6:0] == 7'h7F);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        value_d   = value_q;
        valid_d   = valid_q;
        blank_d   = blank_q;
        dp_d      = dp_q;
        update_d  = 1'b0;
        upd_idx_d = upd_idx_q;
        error_d   = error_q;
        commit    = 1'b0;

        if (in_multi) begin
            error_d = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
        end else if (!in_found) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = TRACK;
                    cnt_d   = CNT_W'(1);
                end
                TRACK: begin
                    if (same) begin
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q + 1'b1 == CNT_W'(STABLE_CYCLES)) begin
                            commit  = 1'b1;
                            state_d = HOLD;
                        end
                    end else begin
                        cnt_d = CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (!same) begin
                        state_d = TRACK;
                        cnt_d   = CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end

        // The input equals the registered sample on a commit edge, so in_idx names its digit.
        if (commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (in_idx == IDX_W'(i)) begin
                    if (code_legal) begin
                        value_d[4*i +: 4] = code_nib;
                        valid_d[i]        = 1'b1;
                        blank_d[i]        = 1'b0;
                        dp_d[i]           = ~seg_q[7];
                        update_d          = 1'b1;
                        upd_idx_d         = in_idx;
                    end else if (code_blank) begin
                        valid_d[i]        = 1'b0;
                        blank_d[i]        = 1'b1;
                        update_d          = 1'b1;
                        upd_idx_d         = in_idx;
                    end else begin
                        valid_d[i]        = 1'b0;
                        blank_d[i]        = 1'b0;
                        error_d           = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            seg_q     <= 8'hFF;
            sel_q     <= '1;
            value_q   <= '0;
            valid_q   <= '0;
            blank_q   <= '0;
            dp_q      <= '0;
            update_q  <= 1'b0;
            upd_idx_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            seg_q     <= bus.SegIn;
            sel_q     <= bus.DigitSel;
            value_q   <= value_d;
            valid_q   <= valid_d;
            blank_q   <= blank_d;
            dp_q      <= dp_d;
            update_q  <= update_d;
            upd_idx_q <= upd_idx_d;
            error_q   <= error_d;
        end
    end

    assign Value      = value_q;
    assign DigitValid = valid_q;
    assign Blank      = blank_q;
    assign Dp         = dp_q;
    assign Update     = update_q;
    assign UpdIdx     = upd_idx_q;
    assign Error      = error_q;
endmodule
